// File: rtl/match_ctrl_if.sv
// match_ctrl_if: control bundle between the match controller and its
// neighbours (move engine, clock divider, draw and link blocks).
interface match_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 2,
    parameter int PID_W       = 1
);
    logic                           tick;
    logic                           start;
    logic                           ack;
    logic                           con_error;
    logic [NUM_PLAYERS-1:0]         alive;
    logic [2:0]                     mode;
    logic                           round_start;
    logic [7:0]                     countdown;
    logic [NUM_PLAYERS*SCORE_W-1:0] score;
    logic [PID_W-1:0]               round_winner;
    logic                           draw;
    logic [PID_W-1:0]               match_winner;
    logic [7:0]                     rounds_played;

    modport master (
        output tick, start, ack, con_error, alive,
        input  mode, round_start, countdown, score,
        input  round_winner, draw, match_winner, rounds_played
    );

    modport slave (
        input  tick, start, ack, con_error, alive,
        output mode, round_start, countdown, score,
        output round_winner, draw, match_winner, rounds_played
    );
endinterface

// File: rtl/match_ctrl.sv
// match_ctrl: best-of-N match/round sequencer for Snake Wars.
// Optional round time limit enabled by defining MATCH_TIMEOUT_EN.
module match_ctrl #(
    parameter int NUM_PLAYERS     = 2,
    parameter int ROUNDS_TO_WIN   = 3,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 1024,
    parameter int SCORE_W         = $clog2(ROUNDS_TO_WIN + 1),
    parameter int PID_W           = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input logic         clk,
    input logic         rst,
    match_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4,
        S_ERROR     = 3'd5
    } state_e;

    localparam int                 SC_TOT  = NUM_PLAYERS * SCORE_W;
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(ROUNDS_TO_WIN);
    localparam logic [7:0]         CD_INIT = 8'(COUNTDOWN_TICKS);

    state_e              state_q;
    logic                round_start_q;
    logic [7:0]          cd_q;
    logic [SC_TOT-1:0]   score_q;
    logic [SC_TOT-1:0]   score_d;
    logic [PID_W-1:0]    rw_q;
    logic [PID_W-1:0]    mw_q;
    logic [PID_W-1:0]    sole_d;
    logic                draw_q;
    logic [7:0]          rounds_q;
    logic [7:0]          rounds_d;
    logic [3:0]          alive_cnt_d;
    logic                won_d;

`ifdef MATCH_TIMEOUT_EN
    localparam int TW = (ROUND_TICKS > 0) ? $clog2(ROUND_TICKS + 1) : 1;
    logic [TW-1:0] tcnt_q;
    logic          tout_d;
    assign tout_d = (tcnt_q + TW'(1)) == TW'(ROUND_TICKS);
`else
    wire unused_round_ticks = (ROUND_TICKS == 0);
`endif

    // Survivor count, sole survivor, its saturated score and match-won flag
    always_comb begin
        alive_cnt_d = '0;
        sole_d      = '0;
        won_d       = 1'b0;
        score_d     = score_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.alive[i]) begin
                alive_cnt_d = alive_cnt_d + 4'd1;
                sole_d      = PID_W'(i);
                if (score_q[i*SCORE_W +: SCORE_W] != WIN)
                    score_d[i*SCORE_W +: SCORE_W] =
                        score_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
            end
            if (score_q[i*SCORE_W +: SCORE_W] == WIN)
                won_d = 1'b1;
        end
        rounds_d = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
    end

    // Match FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_MENU;
            round_start_q <= 1'b0;
            cd_q          <= '0;
            score_q       <= '0;
            rw_q          <= '0;
            mw_q          <= '0;
            draw_q        <= 1'b0;
            rounds_q      <= '0;
`ifdef MATCH_TIMEOUT_EN
            tcnt_q        <= '0;
`endif
        end else begin
            round_start_q <= 1'b0;
`ifdef MATCH_TIMEOUT_EN
            if (state_q != S_PLAY)
                tcnt_q <= '0;
`endif
            unique case (state_q)
                S_MENU: begin
                    if (bus.start) begin
                        score_q       <= '0;
                        rounds_q      <= '0;
                        draw_q        <= 1'b0;
                        rw_q          <= '0;
                        mw_q          <= '0;
                        round_start_q <= 1'b1;
                        cd_q          <= CD_INIT;
                        state_q       <= S_COUNTDOWN;
                    end
                end
                S_COUNTDOWN: begin
                    if (bus.con_error) begin
                        state_q <= S_ERROR;
                    end else if (cd_q == 8'd0) begin
                        state_q <= S_PLAY;
                    end else if (bus.tick) begin
                        cd_q <= cd_q - 8'd1;
                        if (cd_q == 8'd1)
                            state_q <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (bus.con_error) begin
                        state_q <= S_ERROR;
                    end else if (bus.tick) begin
                        if (alive_cnt_d == 4'd0) begin
                            draw_q   <= 1'b1;
                            rounds_q <= rounds_d;
                            state_q  <= S_ROUND_END;
                        end else if (alive_cnt_d == 4'd1) begin
                            rw_q     <= sole_d;
                            score_q  <= score_d;
                            draw_q   <= 1'b0;
                            rounds_q <= rounds_d;
                            state_q  <= S_ROUND_END;
                        end
`ifdef MATCH_TIMEOUT_EN
                        else if (tout_d) begin
                            draw_q   <= 1'b1;
                            rounds_q <= rounds_d;
                            state_q  <= S_ROUND_END;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
`endif
                    end
                end
                S_ROUND_END: begin
                    if (bus.con_error) begin
                        state_q <= S_ERROR;
                    end else if (bus.ack) begin
                        if (won_d) begin
                            mw_q    <= rw_q;
                            state_q <= S_MATCH_END;
                        end else begin
                            cd_q          <= CD_INIT;
                            round_start_q <= 1'b1;
                            state_q       <= S_COUNTDOWN;
                        end
                    end
                end
                S_MATCH_END: begin
                    if (bus.ack)
                        state_q <= S_MENU;
                end
                S_ERROR: begin
                    if (bus.ack)
                        state_q <= S_MENU;
                end
                default: state_q <= S_MENU;
            endcase
        end
    end

    assign bus.mode          = state_q;
    assign bus.round_start   = round_start_q;
    assign bus.countdown     = cd_q;
    assign bus.score         = score_q;
    assign bus.round_winner  = rw_q;
    assign bus.draw          = draw_q;
    assign bus.match_winner  = mw_q;
    assign bus.rounds_played = rounds_q;
endmodule
